// File: rtl/hook_motion_ctrl.sv
// hook_motion_ctrl: frame-rate swing/extend/retract controller feeding draw_hook, one draw per frame
module hook_motion_ctrl #(
   parameter int unsigned MIN_DEG  = 0,
   parameter int unsigned MAX_DEG  = 140,
   parameter int unsigned DEG_STEP = 1,
   parameter int unsigned MIN_LEN  = 16,
   parameter int unsigned MAX_LEN  = 256,
   parameter int unsigned EXT_STEP = 4,
   parameter int unsigned RET_STEP = 4
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       frame_tick,
   input  logic       fire,
   input  logic       hit,
   input  logic [1:0] weight,
   input  logic       draw_done,
   output logic [8:0] degree,
   output logic [9:0] length,
   output logic       draw_enable,
   output logic       busy,
   output logic       grabbed,
   output logic       retract_done,
   output logic       overrun
);
   typedef enum logic [1:0] {S_SWING, S_EXTEND, S_RETRACT} state_t;
   state_t      state_q, state_d;
   logic        dir_q, dir_d, fire_q, fire_pend_q, fire_pend_d;
   logic        busy_q, busy_d, draw_en_q, draw_en_d, grabbed_q, grabbed_d;
   logic        rdone_q, rdone_d, overrun_q, overrun_d;
   logic [1:0]  wq_q, wq_d;
   logic [8:0]  degree_q, degree_d;
   logic [9:0]  length_q, length_d;
   logic        upd, fire_edge;
   logic [31:0] deg_w, len_w, deg_up, len_up, ret_raw, ret_step;

   assign upd       = frame_tick & ~busy_q;
   assign fire_edge = fire & ~fire_q;
   assign deg_w     = 32'(degree_q);
   assign len_w     = 32'(length_q);
   assign deg_up    = deg_w + DEG_STEP;
   assign len_up    = len_w + EXT_STEP;
   assign ret_raw   = grabbed_q ? (RET_STEP >> wq_q) : RET_STEP;
   assign ret_step  = (ret_raw == 32'd0) ? 32'd1 : ret_raw;

   // State register; reset also kills any draw in flight
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_SWING;
         dir_q       <= 1'b1;
         fire_q      <= 1'b0;
         fire_pend_q <= 1'b0;
         busy_q      <= 1'b0;
         draw_en_q   <= 1'b0;
         grabbed_q   <= 1'b0;
         rdone_q     <= 1'b0;
         overrun_q   <= 1'b0;
         wq_q        <= 2'd0;
         degree_q    <= 9'(MIN_DEG);
         length_q    <= 10'(MIN_LEN);
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         fire_q      <= fire;
         fire_pend_q <= fire_pend_d;
         busy_q      <= busy_d;
         draw_en_q   <= draw_en_d;
         grabbed_q   <= grabbed_d;
         rdone_q     <= rdone_d;
         overrun_q   <= overrun_d;
         wq_q        <= wq_d;
         degree_q    <= degree_d;
         length_q    <= length_d;
      end
   end

   // Next-state: draw handshake every cycle, motion only on an accepted frame
   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      degree_d    = degree_q;
      length_d    = length_q;
      wq_d        = wq_q;
      fire_pend_d = fire_pend_q | (fire_edge & (state_q == S_SWING));
      busy_d      = upd | (busy_q & ~draw_done);
      draw_en_d   = upd;
      overrun_d   = frame_tick & busy_q;
      rdone_d     = 1'b0;
      grabbed_d   = grabbed_q & ~rdone_q;
      if (upd) begin
         case (state_q)
            S_SWING:
               if (fire_pend_q) begin
                  state_d     = S_EXTEND;
                  fire_pend_d = 1'b0;
               end else if (dir_q) begin
                  degree_d = (deg_up >= MAX_DEG) ? 9'(MAX_DEG) : 9'(deg_up);
                  dir_d    = ~(deg_up >= MAX_DEG);
               end else begin
                  degree_d = (deg_w <= MIN_DEG + DEG_STEP) ? 9'(MIN_DEG) : 9'(deg_w - DEG_STEP);
                  dir_d    = (deg_w <= MIN_DEG + DEG_STEP);
               end
            S_EXTEND:
               if (hit) begin
                  grabbed_d = 1'b1;
                  wq_d      = weight;
                  state_d   = S_RETRACT;
               end else if (len_up >= MAX_LEN) begin
                  length_d = 10'(MAX_LEN);
                  state_d  = S_RETRACT;
               end else begin
                  length_d = 10'(len_up);
               end
            S_RETRACT:
               if (len_w <= MIN_LEN + ret_step) begin
                  length_d = 10'(MIN_LEN);
                  rdone_d  = 1'b1;
                  state_d  = S_SWING;
               end else begin
                  length_d = 10'(len_w - ret_step);
               end
            default: state_d = S_SWING;
         endcase
      end
   end

   assign degree       = degree_q;
   assign length       = length_q;
   assign draw_enable  = draw_en_q;
   assign busy         = busy_q;
   assign grabbed      = grabbed_q;
   assign retract_done = rdone_q;
   assign overrun      = overrun_q;
endmodule

// File: doc/hook_motion_ctrl.md
# hook_motion_ctrl

Frame-rate controller for the miner's hook, directly upstream of `draw_hook`. It generates the swing angle (`degree`) and rope length (`length`), runs the swing → extend → retract cycle on player fire and object hit, and issues one `draw_enable` pulse per frame to `draw_hook`. It waits for `draw_done` before the next frame, so `degree` and `length` never change while a hook is being drawn.

## Interface
Parameters:
- `MIN_DEG`, 0: lower swing limit (degrees).
- `MAX_DEG`, 140: upper swing limit (degrees). `draw_hook` adds 20 internally.
- `DEG_STEP`, 1: swing increment per frame.
- `MIN_LEN`, 16: rest rope length.
- `MAX_LEN`, 256: maximum rope length.
- `EXT_STEP`, 4: extend increment per frame.
- `RET_STEP`, 4: retract decrement per frame when unloaded.

Ports:
- `clock`  in  1  system clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `frame_tick`  in  1  one-cycle pulse once per video frame.
- `fire`  in  1  player fire button, level. Rising edge detected internally.
- `hit`  in  1  collision detector: the hook tip touches an object. Level, sampled on frame update.
- `weight`  in  2  weight class of the grabbed object. Sampled when `hit` is accepted.
- `draw_done`  in  1  one-cycle done pulse from `draw_hook`.
- `degree`  out  9  swing angle to `draw_hook`.
- `length`  out  10  rope length to `draw_hook`.
- `draw_enable`  out  1  one-cycle start pulse to `draw_hook`.
- `busy`  out  1  a draw is in flight.
- `grabbed`  out  1  an object is attached to the hook.
- `retract_done`  out  1  one-cycle pulse when the hook returns to `MIN_LEN`.
- `overrun`  out  1  one-cycle pulse when a frame is skipped.

## Operation
- Motion FSM states:
  - S_SWING (reset state).
  - S_EXTEND.
  - S_RETRACT.
- Draw handshake flag `busy`, independent of the motion FSM.
- Frame update happens when `frame_tick` arrives and `busy` is 0. Every frame update also sets `busy` and pulses `draw_enable`.
- Fire edge:
  - Register `fire`. Edge = `fire & ~fire_q`.
  - An edge seen in S_SWING sets `fire_pend`.
  - Edges in other states are discarded.
  - `fire_pend` clears on entry to S_EXTEND.
- S_SWING frame update:
  - If `fire_pend` is set, go to S_EXTEND. `degree` is unchanged this frame.
  - Otherwise, with `dir` = 1, `degree` = min(`degree` + `DEG_STEP`, `MAX_DEG`). With `dir` = 0, `degree` = max(`degree` − `DEG_STEP`, `MIN_DEG`). Compare with wide arithmetic; the result never wraps.
  - When `degree` reaches a limit, `dir` flips in the same update.
  - `hit` is ignored.
- S_EXTEND frame update (`degree` frozen):
  - If `hit` = 1: `grabbed` ← 1, latch `weight` into `wq`, go to S_RETRACT. `length` is unchanged.
  - Else if `length` + `EXT_STEP` ≥ `MAX_LEN`: `length` ← `MAX_LEN`, go to S_RETRACT.
  - Else `length` += `EXT_STEP`.
- S_RETRACT frame update:
  - Step = `RET_STEP >> wq` when `grabbed`, else `RET_STEP`. Minimum step is 1.
  - If `length` ≤ `MIN_LEN` + step: `length` ← `MIN_LEN`, pulse `retract_done` (with `grabbed` still 1 in that cycle), clear `grabbed` on the next cycle, go to S_SWING.
  - Else `length` −= step.
- Draw handshake:
  - `busy` clears on the cycle after `draw_done`.
  - A `frame_tick` while `busy` = 1 causes no motion update, pulses `overrun`, and queues nothing.
  - `draw_done` while not busy is ignored.

## Timing
- Reset values:
  - Outputs: `degree` = `MIN_DEG`, `length` = `MIN_LEN`. `draw_enable`, `busy`, `grabbed`, `retract_done` and `overrun` are all 0.
  - Internal: `dir` = 1, `fire_pend` = 0, `fire_q` = 0, `wq` = 0, state S_SWING.
- Reset asserted mid-operation clears everything immediately, including a draw in flight. A later `draw_done` is ignored.
- `frame_tick` high in cycle T with `busy` = 0:
  - New `degree` and `length` are registered at the T/T+1 edge.
  - `draw_enable` = 1 during cycle T+1 only.
  - `busy` = 1 from T+1.
  - `retract_done`, when it fires, is a pulse in T+1.
- `draw_done` high in cycle D: `busy` = 0 from D+1. A `frame_tick` in cycle D is an overrun. A `frame_tick` in cycle D+1 is accepted.
- A fire edge in the same cycle as an accepted `frame_tick` is not seen by that update. It takes effect on the next frame.
- `degree` and `length` are stable for the whole time `busy` = 1.

## Test plan
- Reset, then 141 ticks, each answered with `draw_done` 5 cycles after `draw_enable`. Required: `degree` goes 1, 2, … 140; the next tick gives 139. `draw_enable` pulses exactly 141 times.
- At `degree` = 30, pulse `fire`, then run ticks with no `hit`. Required: `degree` holds at 30. `length` goes 16, 20, … 252, then 256, then retracts 252 … 20, then 16 with `retract_done` = 1 and `grabbed` = 0. Swing resumes at degree 31.
- While extending at `length` = 100, assert `hit` with `weight` = 2. Required: `grabbed` = 1 and `length` holds at 100. Retract steps by 1 per frame. At 16, `retract_done` = 1 with `grabbed` = 1, then `grabbed` = 0.
- Send a tick, withhold `draw_done`, and send 3 more ticks. Required: 3 `overrun` pulses and no change to `degree` or `length`. `draw_done` in cycle D with a tick in cycle D+1 gives `draw_enable` in D+2.
- Pulse `fire` during S_RETRACT. Required: no effect. Assert `resetn` = 0 asynchronously mid-extend. Required: all outputs return to reset values within the same cycle, with no clock edge needed.
